sw_debouncer: RTL and testbench

Input conditioning stage placed directly upstream of the LED top level: takes raw asynchronous slide-switch levels, synchronizes them into the `clock` domain, filters contact bounce per bit, and drives clean levels plus one-cycle edge pulses. Its `o_sw` bus feeds the top level's `i_sw` (speed-select bits and colour-select bit). Without it, switch bounce produces erratic counter-rate changes and colour flicker.

---
 rtl/sw_debouncer.sv | 115 +++++++++++
 tb/tb_sw_debouncer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sw_debouncer.sv
// Slide-switch conditioner: two-flop synchronizer, then a per-bit bounce filter that
// accepts a new level after DB_LIMIT consecutive mismatching samples and pulses on each edge.
//   state     | meaning
//   ST_STABLE | synchronized input equals accepted level; counter parked at 0
//   ST_CHECK  | input differs from accepted level; counting consecutive mismatches
module sw_debouncer #(
    parameter int NB_SW         = 4,
    parameter int NB_DB_COUNTER = 20,
    parameter int DB_LIMIT      = 1000000
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    output logic [NB_SW-1:0] o_sw,
    output logic [NB_SW-1:0] o_sw_rise,
    output logic [NB_SW-1:0] o_sw_fall
);

    localparam logic [NB_DB_COUNTER-1:0] LP_CNT_LAST = NB_DB_COUNTER'(DB_LIMIT - 1);
    localparam logic [NB_DB_COUNTER-1:0] LP_CNT_ONE  = NB_DB_COUNTER'(1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    logic [NB_SW-1:0]         r_sync1;
    logic [NB_SW-1:0]         r_sync2;
    logic [NB_SW-1:0]         r_sw;
    logic [NB_SW-1:0]         r_rise;
    logic [NB_SW-1:0]         r_fall;
    state_t                   r_state      [NB_SW];
    logic [NB_DB_COUNTER-1:0] r_cnt        [NB_SW];

    logic [NB_SW-1:0]         w_sw_next;
    logic [NB_SW-1:0]         w_rise_next;
    logic [NB_SW-1:0]         w_fall_next;
    state_t                   w_state_next [NB_SW];
    logic [NB_DB_COUNTER-1:0] w_cnt_next   [NB_SW];

    // Plain flop-to-flop synchronizer; only r_sync2 is consumed.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_sw   <= '0;
            r_rise <= '0;
            r_fall <= '0;
            for (int i = 0; i < NB_SW; i++) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_sw   <= w_sw_next;
            r_rise <= w_rise_next;
            r_fall <= w_fall_next;
            for (int i = 0; i < NB_SW; i++) begin
                r_state[i] <= w_state_next[i];
                r_cnt[i]   <= w_cnt_next[i];
            end
        end
    end

    always_comb begin
        w_sw_next   = r_sw;
        w_rise_next = '0;
        w_fall_next = '0;
        for (int i = 0; i < NB_SW; i++) begin
            w_state_next[i] = r_state[i];
            w_cnt_next[i]   = r_cnt[i];
            case (r_state[i])
                ST_STABLE: begin
                    if (r_sync2[i] != r_sw[i]) begin
                        w_state_next[i] = ST_CHECK;
                        w_cnt_next[i]   = LP_CNT_ONE;
                    end else begin
                        w_cnt_next[i]   = '0;
                    end
                end
                ST_CHECK: begin
                    if (r_sync2[i] == r_sw[i]) begin
                        // Bounced back: qualification restarts from zero.
                        w_state_next[i] = ST_STABLE;
                        w_cnt_next[i]   = '0;
                    end else if (r_cnt[i] == LP_CNT_LAST) begin
                        w_state_next[i] = ST_STABLE;
                        w_cnt_next[i]   = '0;
                        w_sw_next[i]    = r_sync2[i];
                        w_rise_next[i]  = r_sync2[i];
                        w_fall_next[i]  = ~r_sync2[i];
                    end else begin
                        w_cnt_next[i]   = r_cnt[i] + LP_CNT_ONE;
                    end
                end
                default: begin
                    w_state_next[i] = ST_STABLE;
                    w_cnt_next[i]   = '0;
                end
            endcase
        end
    end

    assign o_sw      = r_sw;
    assign o_sw_rise = r_rise;
    assign o_sw_fall = r_fall;

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with DB_LIMIT=8: acceptance lands 10 edges after an input change.
module tb_sw_debouncer;

    logic       clock;
    logic       i_reset;
    logic [3:0] i_sw;
    logic [3:0] o_sw;
    logic [3:0] o_sw_rise;
    logic [3:0] o_sw_fall;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        int         n;
        logic [3:0] e_sw;
        logic [3:0] e_rise;
        logic [3:0] e_fall;
    } vec_t;

    vec_t vecs[$];

    sw_debouncer #(
        .NB_SW         (4),
        .NB_DB_COUNTER (4),
        .DB_LIMIT      (8)
    ) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_sw      (i_sw),
        .o_sw      (o_sw),
        .o_sw_rise (o_sw_rise),
        .o_sw_fall (o_sw_fall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_sw,
                             input logic [3:0] e_rise, input logic [3:0] e_fall);
        check({tag, ".o_sw"}, o_sw, e_sw);
        check({tag, ".rise"}, o_sw_rise, e_rise);
        check({tag, ".fall"}, o_sw_fall, e_fall);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic rst, input logic [3:0] sw, input int n,
                       input logic [3:0] e_sw, input logic [3:0] e_rise, input logic [3:0] e_fall);
        vec_t v;
        v.rst = rst; v.sw = sw; v.n = n;
        v.e_sw = e_sw; v.e_rise = e_rise; v.e_fall = e_fall;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        i_reset = 1'b1;
        i_sw    = 4'b1111;

        // reset held with switches high, then release: rise on all bits at the 10th edge
        add(1, 4'b1111, 3, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b1111, 9, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b1111, 1, 4'b1111, 4'b1111, 4'b0000);
        add(0, 4'b1111, 2, 4'b1111, 4'b0000, 4'b0000);
        // all low again: fall on every bit
        add(0, 4'b0000, 9, 4'b1111, 4'b0000, 4'b0000);
        add(0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b1111);
        add(0, 4'b0000, 2, 4'b0000, 4'b0000, 4'b0000);
        // clean step on bit 0
        add(0, 4'b0001, 9, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 1, 4'b0001, 4'b0001, 4'b0000);
        add(0, 4'b0001, 2, 4'b0001, 4'b0000, 4'b0000);
        // bounce on bit 1: 5 high, 1 low, then steady high
        add(0, 4'b0011, 5, 4'b0001, 4'b0000, 4'b0000);
        add(0, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000);
        add(0, 4'b0011, 9, 4'b0001, 4'b0000, 4'b0000);
        add(0, 4'b0011, 1, 4'b0011, 4'b0010, 4'b0000);
        add(0, 4'b0011, 2, 4'b0011, 4'b0000, 4'b0000);
        // glitch on bit 2: 6 high cycles never accepted
        add(0, 4'b0111, 6, 4'b0011, 4'b0000, 4'b0000);
        add(0, 4'b0011, 12, 4'b0011, 4'b0000, 4'b0000);
        // move to 1000 (rise bit 3, fall bits 1:0 together)
        add(0, 4'b1000, 9, 4'b0011, 4'b0000, 4'b0000);
        add(0, 4'b1000, 1, 4'b1000, 4'b1000, 4'b0011);
        add(0, 4'b1000, 2, 4'b1000, 4'b0000, 4'b0000);
        // simultaneous rise bit 2 / fall bit 3
        add(0, 4'b0100, 9, 4'b1000, 4'b0000, 4'b0000);
        add(0, 4'b0100, 1, 4'b0100, 4'b0100, 4'b1000);
        add(0, 4'b0100, 2, 4'b0100, 4'b0000, 4'b0000);

        for (int k = 0; k < vecs.size(); k++) begin
            i_reset = vecs[k].rst;
            i_sw    = vecs[k].sw;
            for (int c = 0; c < vecs[k].n; c++) begin
                step();
                check_all($sformatf("vec%0d.c%0d", k, c), vecs[k].e_sw, vecs[k].e_rise, vecs[k].e_fall);
            end
        end

        // mid-count asynchronous reset: bit 0 rising, cnt[0] is 5 after 7 edges
        i_sw = 4'b0101;
        for (int c = 0; c < 7; c++) begin
            step();
            check_all($sformatf("midcnt.c%0d", c), 4'b0100, 4'b0000, 4'b0000);
        end
        #2;
        i_reset = 1'b1;
        #1;
        check_all("async_rst", 4'b0000, 4'b0000, 4'b0000);
        step();
        check_all("rst_held", 4'b0000, 4'b0000, 4'b0000);
        i_reset = 1'b0;
        for (int c = 0; c < 9; c++) begin
            step();
            check_all($sformatf("requal.c%0d", c), 4'b0000, 4'b0000, 4'b0000);
        end
        step();
        check_all("requal.accept", 4'b0101, 4'b0101, 4'b0000);
        step();
        check_all("requal.after", 4'b0101, 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
